// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   u32_t      : 32-bit address / data word
//   wrstb_t    : 4-bit byte write strobes, all-zero means read
//   dmem_req_t : one requester's memory request fields
//   PORT_CORE / PORT_DBG : port indices (core LSU / debug-DMA)
package dmem_arbiter_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    typedef struct packed {
        u32_t   addr;
        u32_t   wrdata;
        wrstb_t wrstb;
    } dmem_req_t;

    localparam logic   PORT_CORE  = 1'b0;
    localparam logic   PORT_DBG   = 1'b1;
    localparam wrstb_t WRSTB_NONE = 4'b0000;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 (core LSU) has fixed priority; port 1 (debug/DMA) is promoted after
// STARVE_LIMIT consecutive grants to port 0 while it was waiting.
// One transaction in flight; a response can be retired in the same cycle a new
// request is granted, giving one transaction per clock.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_valid / o_req_ready      per-port request handshake (ready is combinational)
//   i_req_addr_N/_wrdata_N/_wrstb_N request fields of port N
//   o_rsp_valid / i_rsp_ready      per-port response handshake (valid is registered)
//   o_rsp_rddata                   shared response data (pre-write memory contents)
//   o_mem_addr/_wrdata/_wrstb      to dmem; strobes nonzero only in a grant cycle
//   i_mem_rddata                   from dmem, combinational read
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req_valid,
    output logic [1:0]  o_req_ready,
    input  logic [31:0] i_req_addr_0,
    input  logic [31:0] i_req_wrdata_0,
    input  logic [3:0]  i_req_wrstb_0,
    input  logic [31:0] i_req_addr_1,
    input  logic [31:0] i_req_wrdata_1,
    input  logic [3:0]  i_req_wrstb_1,
    output logic [1:0]  o_rsp_valid,
    input  logic [1:0]  i_rsp_ready,
    output logic [31:0] o_rsp_rddata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wrdata,
    output logic [3:0]  o_mem_wrstb,
    input  logic [31:0] i_mem_rddata
);

    typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       r_state;
    logic             r_owner;
    logic [1:0]       r_rsp_valid;
    u32_t             r_rsp_rddata;
    logic [CNT_W-1:0] r_starve_cnt;

    arb_state_t       w_state_nxt;
    logic             w_owner_nxt;
    logic [1:0]       w_rsp_valid_nxt;
    u32_t             w_rsp_rddata_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    dmem_req_t        w_req0;
    dmem_req_t        w_req1;
    dmem_req_t        w_sel;
    logic             w_hs;
    logic             w_can_grant;
    logic             w_grant;
    logic             w_win;
    logic [1:0]       w_onehot;

    assign w_req0 = '{addr: i_req_addr_0, wrdata: i_req_wrdata_0, wrstb: i_req_wrstb_0};
    assign w_req1 = '{addr: i_req_addr_1, wrdata: i_req_wrdata_1, wrstb: i_req_wrstb_1};

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB_IDLE;
            r_owner      <= PORT_CORE;
            r_rsp_valid  <= 2'b00;
            r_rsp_rddata <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_rddata <= w_rsp_rddata_nxt;
            r_starve_cnt <= w_cnt_nxt;
        end
    end

    // Next-state logic: grant decision, response retire, starvation counter
    always_comb begin
        // Only the owner's rsp_ready can retire the pending response.
        w_hs        = r_rsp_valid[r_owner] & i_rsp_ready[r_owner];
        w_can_grant = (r_state == ARB_IDLE) | ((r_state == ARB_RESP) & w_hs);
        w_win       = ((i_req_valid == 2'b10) |
                       ((i_req_valid == 2'b11) & (r_starve_cnt == LIMIT))) ? PORT_DBG : PORT_CORE;
        // Gating with reset keeps strobes off dmem while reset is asserted.
        w_grant     = i_rst_n & w_can_grant & (|i_req_valid);

        w_onehot        = 2'b00;
        w_onehot[w_win] = 1'b1;

        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_rddata_nxt = r_rsp_rddata;
        if (w_grant) begin
            w_state_nxt      = ARB_RESP;
            w_owner_nxt      = w_win;
            w_rsp_valid_nxt  = w_onehot;
            // Memory read is combinational, so this captures pre-write contents.
            w_rsp_rddata_nxt = i_mem_rddata;
        end else if ((r_state == ARB_RESP) && w_hs) begin
            w_state_nxt     = ARB_IDLE;
            w_rsp_valid_nxt = 2'b00;
        end

        w_cnt_nxt = r_starve_cnt;
        if (!i_req_valid[1] || (w_grant && (w_win == PORT_DBG))) begin
            w_cnt_nxt = '0;
        end else if (w_grant && (r_starve_cnt != LIMIT)) begin
            w_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    // Output logic
    always_comb begin
        w_sel        = (w_grant && (w_win == PORT_DBG)) ? w_req1 : w_req0;
        o_req_ready  = w_grant ? w_onehot : 2'b00;
        o_mem_addr   = i_rst_n ? w_sel.addr   : '0;
        o_mem_wrdata = i_rst_n ? w_sel.wrdata : '0;
        o_mem_wrstb  = w_grant ? w_sel.wrstb  : WRSTB_NONE;
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rddata = r_rsp_rddata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// compared each cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v;
    logic [1:0]  rr;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  s [2];

    logic [1:0]  o_req_ready;
    logic [1:0]  o_rsp_valid;
    logic [31:0] o_rsp_rddata;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wrdata;
    logic [3:0]  o_mem_wrstb;
    logic [31:0] mem_rddata;

    // dmem environment: 16 words, combinational read, strobed write
    logic [31:0] dmem [16] = '{default: 32'h0};
    assign mem_rddata = dmem[o_mem_addr[5:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (o_mem_wrstb[b]) dmem[o_mem_addr[5:2]][8*b +: 8] <= o_mem_wrdata[8*b +: 8];
    end

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(v), .o_req_ready(o_req_ready),
        .i_req_addr_0(a[0]), .i_req_wrdata_0(d[0]), .i_req_wrstb_0(s[0]),
        .i_req_addr_1(a[1]), .i_req_wrdata_1(d[1]), .i_req_wrstb_1(s[1]),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rr), .o_rsp_rddata(o_rsp_rddata),
        .o_mem_addr(o_mem_addr), .o_mem_wrdata(o_mem_wrdata), .o_mem_wrstb(o_mem_wrstb),
        .i_mem_rddata(mem_rddata)
    );

    // Reference model: one outstanding transaction, a word-array memory image
    logic [31:0] rmem [16];
    bit          m_pend;
    int          m_port;
    logic [31:0] m_rdata;
    int          m_cnt;
    bit          g_valid;
    int          g_port;
    logic [1:0]  obs_ready;
    logic [1:0]  obs_rspv;
    logic [31:0] obs_rdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_port  = 0;
        m_rdata = 32'h0;
        m_cnt   = 0;
        g_valid = 0;
        g_port  = 0;
    endtask

    // Called just after a posedge with inputs settled; checks at the negedge,
    // advances the model at the next posedge.
    task automatic step();
        bit         grant;
        int         w;
        int         idx;
        logic [1:0] exp_rdy;
        @(negedge clk);
        grant = 0;
        w     = 0;
        if (!m_pend || rr[m_port]) begin
            if (v == 2'b11) begin
                grant = 1;
                w     = (m_cnt == LIMIT) ? 1 : 0;
            end else if (v[0]) begin
                grant = 1;
                w     = 0;
            end else if (v[1]) begin
                grant = 1;
                w     = 1;
            end
        end
        exp_rdy   = grant ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        obs_ready = o_req_ready;
        obs_rspv  = o_rsp_valid;
        obs_rdata = o_rsp_rddata;
        chk("req_ready",  o_req_ready,  exp_rdy);
        chk("mem_wrstb",  o_mem_wrstb,  grant ? s[w] : 4'b0000);
        chk("mem_addr",   o_mem_addr,   grant ? a[w] : a[0]);
        chk("mem_wrdata", o_mem_wrdata, grant ? d[w] : d[0]);
        chk("rsp_valid",  o_rsp_valid,  m_pend ? ((m_port == 1) ? 2'b10 : 2'b01) : 2'b00);
        chk("rsp_rddata", o_rsp_rddata, m_rdata);
        @(posedge clk);
        if (!v[1] || (grant && w == 1)) m_cnt = 0;
        else if (grant && m_cnt < LIMIT) m_cnt++;
        if (grant) begin
            idx     = int'(a[w][5:2]);
            m_rdata = rmem[idx];
            for (int b = 0; b < 4; b++)
                if (s[w][b]) rmem[idx][8*b +: 8] = d[w][8*b +: 8];
            m_pend = 1;
            m_port = w;
        end else if (m_pend && rr[m_port]) begin
            m_pend = 0;
        end
        g_valid = grant;
        g_port  = w;
        #1;
    endtask

    task automatic new_req(input int p);
        v[p] = 1'($urandom_range(0, 1));
        a[p] = 32'($urandom_range(0, 63));
        d[p] = $urandom;
        s[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
    endtask

    initial begin
        int          p1_at;
        logic [31:0] held;

        for (int i = 0; i < 16; i++) rmem[i] = 32'h0;
        model_reset();
        rst_n = 1'b0;
        v     = 2'b11;
        rr    = 2'b11;
        for (int p = 0; p < 2; p++) begin
            a[p] = 32'h40 + 32'(p);
            d[p] = 32'hDEAD_0000;
            s[p] = 4'b1111;
        end

        // Reset state with both requesters asserting writes
        #2;
        chk("rst_req_ready",  o_req_ready,  2'b00);
        chk("rst_mem_wrstb",  o_mem_wrstb,  4'b0000);
        chk("rst_mem_addr",   o_mem_addr,   32'h0);
        chk("rst_mem_wrdata", o_mem_wrdata, 32'h0);
        chk("rst_rsp_valid",  o_rsp_valid,  2'b00);
        chk("rst_rsp_rddata", o_rsp_rddata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        v     = 2'b00;
        rst_n = 1'b1;
        step();

        // Port 0 write, then read back
        v = 2'b01; a[0] = 32'h10; d[0] = 32'hA5A5A5A5; s[0] = 4'b1111; rr = 2'b11;
        step();
        chk("wr_accept", obs_ready, 2'b01);
        d[0] = 32'h0; s[0] = 4'b0000;
        step();
        chk("wr_ack_valid", obs_rspv, 2'b01);
        chk("wr_ack_old",   obs_rdata, 32'h0);
        v = 2'b00;
        step();
        chk("rd_data", obs_rdata, 32'hA5A5A5A5);
        step();

        // Both valid: port 0 wins until port 1 is promoted on the 9th grant
        v = 2'b11; a[0] = 32'h20; s[0] = 4'b0000; a[1] = 32'h30; d[1] = 32'h0; s[1] = 4'b0000;
        p1_at = 0;
        for (int i = 1; i <= 12; i++) begin
            if (p1_at == 0) begin
                step();
                if (i == 1) chk("both_p0_first", obs_ready, 2'b01);
                if (obs_ready == 2'b10) p1_at = i;
            end
        end
        chk("starve_grant_idx", 32'(p1_at), 32'd9);
        a[1] = 32'h34;
        step();
        chk("after_starve_p0", obs_ready, 2'b01);

        // Response stall on port 0 with both requesters waiting
        rr = 2'b00; a[0] = 32'h24; d[0] = 32'h1234_5678; s[0] = 4'b0011;
        held = 32'h0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) held = obs_rdata;
            chk("stall_ready", obs_ready, 2'b00);
            chk("stall_rspv",  obs_rspv,  2'b01);
            chk("stall_data",  obs_rdata, held);
        end
        rr = 2'b01;
        step();
        chk("stall_release", obs_ready, 2'b01);

        // Back-to-back: retire port-0 response and grant port-1 read in one cycle
        v = 2'b10; rr = 2'b01;
        step();
        chk("b2b_ready", obs_ready, 2'b10);
        v = 2'b00; rr = 2'b00;
        step();
        chk("b2b_rspv", obs_rspv, 2'b10);

        // Reset mid-response with a write waiting on port 0
        v = 2'b01; a[0] = 32'h8; d[0] = 32'hFFFF_FFFF; s[0] = 4'b1111;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rspv",  o_rsp_valid,  2'b00);
        chk("midrst_data",  o_rsp_rddata, 32'h0);
        chk("midrst_ready", o_req_ready,  2'b00);
        chk("midrst_wrstb", o_mem_wrstb,  4'b0000);
        model_reset();
        @(posedge clk);
        #1;
        v     = 2'b00;
        rst_n = 1'b1;
        step();

        // Random traffic obeying the requester rules
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(v[p] && !(g_valid && g_port == p))) new_req(p);
            end
            rr[0] = ($urandom_range(0, 3) != 0);
            rr[1] = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
